boreal_frame_sequencer: RTL and testbench

// - Parametrised multi-channel frame assembler between the ADC SPI front-end and the feature chain.
// - Collects N_CH serial (channel, sample) beats into one packed frame and stamps it with a frame ID.
// - Presents each frame on a valid/ready output with a one-frame holding register.
// - Detects out-of-order channels, downstream overrun and ADC stall (missing DRDY).

---
 rtl/boreal_frame_sequencer.sv | 144 ++++++++++++++
 tb/tb_boreal_frame_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boreal_frame_sequencer.sv
// Multi-channel frame assembler: collects N_CH (channel, sample) beats into one frame,
// stamps it with a frame ID and holds it on a valid/ready output; flags order, overrun, stall.
module boreal_frame_sequencer #(
    parameter int unsigned N_CH          = 8,
    parameter int unsigned SAMPLE_W      = 24,
    parameter int unsigned FID_W         = 8,
    parameter int unsigned TIMEOUT_TICKS = 4,
    localparam int unsigned CW           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [CW-1:0]              in_ch,
    input  logic [SAMPLE_W-1:0]        in_sample,
    input  logic                       tick_1khz,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [N_CH*SAMPLE_W-1:0]   out_frame,
    output logic [FID_W-1:0]           out_frame_id,
    input  logic                       clear_err,
    output logic                       err_seq,
    output logic                       err_overrun,
    output logic                       stall,
    output logic [15:0]                drop_cnt
);

    localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
    localparam int unsigned FW = N_CH * SAMPLE_W;

    logic [FW-1:0]       asm_q, asm_d;
    logic [CW-1:0]       exp_ch_q, exp_ch_d;
    logic [FID_W-1:0]    fid_q, fid_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic                out_valid_q, out_valid_d;
    logic [FW-1:0]       out_frame_q, out_frame_d;
    logic [FID_W-1:0]    out_id_q, out_id_d;
    logic                err_seq_q, err_seq_d;
    logic                err_ovr_q, err_ovr_d;
    logic                stall_q, stall_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;

    logic beat_ok, seq_err, restart, last_lane, complete, can_load, load, drop, wr_en;
    logic [CW-1:0] wr_lane;

    always_comb begin
        beat_ok   = in_valid && (in_ch == exp_ch_q);
        seq_err   = in_valid && !beat_ok;
        restart   = seq_err && (in_ch == '0);
        last_lane = (exp_ch_q == CW'(N_CH - 1));
        complete  = (beat_ok && last_lane) || (restart && (N_CH == 1));
        wr_en     = beat_ok || restart;
        wr_lane   = beat_ok ? exp_ch_q : '0;

        // Buffer including the current beat, so a completing frame carries its final lane
        asm_d = asm_q;
        for (int k = 0; k < N_CH; k++) begin
            if (wr_en && (wr_lane == CW'(k))) begin
                asm_d[k*SAMPLE_W +: SAMPLE_W] = in_sample;
            end
        end

        if (beat_ok) begin
            exp_ch_d = last_lane ? '0 : exp_ch_q + CW'(1);
        end else if (restart) begin
            exp_ch_d = (N_CH == 1) ? '0 : CW'(1);
        end else if (seq_err) begin
            exp_ch_d = '0;
        end else begin
            exp_ch_d = exp_ch_q;
        end

        can_load = !out_valid_q || out_ready;
        load     = complete && can_load;
        drop     = complete && !can_load;

        if (load) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        out_frame_d = load ? asm_d : out_frame_q;
        out_id_d    = load ? fid_q : out_id_q;
        fid_d       = complete ? fid_q + FID_W'(1) : fid_q;

        // A new error in the same cycle as clear_err wins
        err_seq_d = seq_err || (err_seq_q && !clear_err);
        err_ovr_d = drop || (err_ovr_q && !clear_err);
        if (clear_err) begin
            drop_cnt_d = drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        if (complete) begin
            tcnt_d = '0;
        end else if (tick_1khz && (tcnt_q != TW'(TIMEOUT_TICKS))) begin
            tcnt_d = tcnt_q + TW'(1);
        end else begin
            tcnt_d = tcnt_q;
        end
        stall_d = (tcnt_d == TW'(TIMEOUT_TICKS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q       <= '0;
            exp_ch_q    <= '0;
            fid_q       <= '0;
            tcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_frame_q <= '0;
            out_id_q    <= '0;
            err_seq_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
            stall_q     <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            asm_q       <= asm_d;
            exp_ch_q    <= exp_ch_d;
            fid_q       <= fid_d;
            tcnt_q      <= tcnt_d;
            out_valid_q <= out_valid_d;
            out_frame_q <= out_frame_d;
            out_id_q    <= out_id_d;
            err_seq_q   <= err_seq_d;
            err_ovr_q   <= err_ovr_d;
            stall_q     <= stall_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_frame    = out_frame_q;
    assign out_frame_id = out_id_q;
    assign err_seq      = err_seq_q;
    assign err_overrun  = err_ovr_q;
    assign stall        = stall_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_boreal_frame_sequencer.sv
// Self-checking bench for boreal_frame_sequencer (default parameters, N_CH=8).
// Expected frames are queued as they are driven and popped on each output handshake.
module tb_boreal_frame_sequencer;

    localparam int NCH = 8;
    localparam int SW  = 24;
    localparam int FW  = NCH * SW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [2:0]    in_ch = '0;
    logic [SW-1:0] in_sample = '0;
    logic          tick_1khz = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [FW-1:0] out_frame;
    logic [7:0]    out_frame_id;
    logic          clear_err = 1'b0;
    logic          err_seq;
    logic          err_overrun;
    logic          stall;
    logic [15:0]   drop_cnt;

    typedef struct packed {
        logic [7:0]    id;
        logic [FW-1:0] frame;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] fid_model = '0;
    int         checks = 0;
    int         errors = 0;

    boreal_frame_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ch        (in_ch),
        .in_sample    (in_sample),
        .tick_1khz    (tick_1khz),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_frame    (out_frame),
        .out_frame_id (out_frame_id),
        .clear_err    (clear_err),
        .err_seq      (err_seq),
        .err_overrun  (err_overrun),
        .stall        (stall),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    // Handshake completes at the next rising edge; sample it on the falling edge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: unexpected frame id=%0d, none expected", out_frame_id);
            end else begin
                e = sb.pop_front();
                if (out_frame_id !== e.id || out_frame !== e.frame) begin
                    errors++;
                    $display("FAIL scoreboard: got id=%0d frame=%h, expected id=%0d frame=%h",
                             out_frame_id, out_frame, e.id, e.frame);
                end
            end
        end
    end

    function automatic logic [FW-1:0] mk(input logic [SW-1:0] base);
        logic [FW-1:0] f;
        for (int k = 0; k < NCH; k++) f[k*SW +: SW] = base + SW'(k);
        return f;
    endfunction

    task automatic beat(input int ch, input logic [SW-1:0] s, input logic clr);
        in_valid  = 1'b1;
        in_ch     = 3'(ch);
        in_sample = s;
        clear_err = clr;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full in-order frame; pushes an expectation only when it should load
    task automatic send_frame(input logic [SW-1:0] base, input bit loads, input logic clr_last);
        if (loads) sb.push_back('{id: fid_model, frame: mk(base)});
        fid_model++;
        for (int k = 0; k < NCH; k++) beat(k, base + SW'(k), (k == NCH - 1) ? clr_last : 1'b0);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        sb.delete();
        fid_model = '0;
        out_ready = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s drain: %0d frames still expected, 0 required", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        checks++;
        if ({out_valid, out_frame_id, err_seq, err_overrun, stall, drop_cnt} !== '0 ||
            out_frame !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b id=%0d seq=%b ovr=%b stall=%b drop=%0d, all 0",
                     out_valid, out_frame_id, err_seq, err_overrun, stall, drop_cnt);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_basic();
        do_reset();
        out_ready = 1'b1;
        sb.push_back('{id: fid_model, frame: mk(24'd1)});
        fid_model++;
        for (int k = 0; k < NCH; k++) begin
            beat(k, 24'(k + 1), 1'b0);
            if (k == NCH - 2) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_early_valid: out_valid=%b, required 0", out_valid);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_frame_id !== 8'd0) begin
            errors++;
            $display("FAIL basic_latency: valid=%b id=%0d, required valid=1 id=0",
                     out_valid, out_frame_id);
        end
        send_frame(24'h100, 1'b1, 1'b0);
        checks++;
        if (out_frame_id !== 8'd1) begin
            errors++;
            $display("FAIL basic_second_id: id=%0d, required 1", out_frame_id);
        end
        idle(2);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_consumed: out_valid=%b, required 0", out_valid);
        end
        check_drained("basic");
    endtask

    task automatic test_overrun();
        do_reset();
        send_frame(24'h010, 1'b1, 1'b0);
        send_frame(24'h020, 1'b0, 1'b0);
        send_frame(24'h030, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_frame_id !== 8'd0 || out_frame !== mk(24'h010)) begin
            errors++;
            $display("FAIL overrun_hold: valid=%b id=%0d frame=%h, required 1/0/%h",
                     out_valid, out_frame_id, out_frame, mk(24'h010));
        end
        checks++;
        if (err_overrun !== 1'b1 || drop_cnt !== 16'd2) begin
            errors++;
            $display("FAIL overrun_flags: err_overrun=%b drop_cnt=%0d, required 1/2",
                     err_overrun, drop_cnt);
        end
        out_ready = 1'b1;
        idle(1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_consume: out_valid=%b, required 0", out_valid);
        end
        check_drained("overrun");
    endtask

    task automatic test_seq();
        do_reset();
        out_ready = 1'b1;
        beat(0, 24'hA0, 1'b0);
        beat(1, 24'hA1, 1'b0);
        beat(2, 24'hA2, 1'b0);
        checks++;
        if (err_seq !== 1'b0) begin
            errors++;
            $display("FAIL seq_early: err_seq=%b, required 0", err_seq);
        end
        beat(5, 24'hA5, 1'b0);
        checks++;
        if (err_seq !== 1'b1) begin
            errors++;
            $display("FAIL seq_flag: err_seq=%b, required 1", err_seq);
        end
        send_frame(24'h200, 1'b1, 1'b0);
        checks++;
        if (out_frame_id !== 8'd0) begin
            errors++;
            $display("FAIL seq_no_id_consumed: id=%0d, required 0", out_frame_id);
        end
        // Second ch0 restarts the frame and becomes its lane 0
        sb.push_back('{id: fid_model, frame: mk(24'h300)});
        fid_model++;
        beat(0, 24'h3F0, 1'b0);
        beat(1, 24'h3F1, 1'b0);
        for (int k = 0; k < NCH; k++) beat(k, 24'h300 + 24'(k), 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_frame_id !== 8'd1) begin
            errors++;
            $display("FAIL seq_restart: valid=%b id=%0d, required 1/1", out_valid, out_frame_id);
        end
        idle(2);
        check_drained("seq");
    endtask

    task automatic test_watchdog();
        do_reset();
        out_ready = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            tick_1khz = 1'b1;
            idle(1);
            tick_1khz = 1'b0;
            idle(2);
            checks++;
            if (stall !== (t == 4)) begin
                errors++;
                $display("FAIL watchdog_tick%0d: stall=%b, required %b", t, stall, t == 4);
            end
        end
        send_frame(24'h400, 1'b1, 1'b0);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL watchdog_clear: stall=%b, required 0", stall);
        end
        idle(2);
        check_drained("watchdog");
    endtask

    task automatic test_clear();
        do_reset();
        beat(3, 24'hBAD, 1'b0);
        send_frame(24'h500, 1'b1, 1'b0);
        send_frame(24'h600, 1'b0, 1'b0);
        send_frame(24'h700, 1'b0, 1'b1);
        checks++;
        if (err_overrun !== 1'b1 || drop_cnt !== 16'd1 || err_seq !== 1'b0) begin
            errors++;
            $display("FAIL clear_with_drop: ovr=%b drop=%0d seq=%b, required 1/1/0",
                     err_overrun, drop_cnt, err_seq);
        end
        clear_err = 1'b1;
        idle(1);
        clear_err = 1'b0;
        checks++;
        if (err_overrun !== 1'b0 || drop_cnt !== 16'd0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL clear_alone: ovr=%b drop=%0d valid=%b, required 0/0/1",
                     err_overrun, drop_cnt, out_valid);
        end
        out_ready = 1'b1;
        idle(2);
        check_drained("clear");
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_frame(24'h800, 1'b1, 1'b0);
        sb.push_back('{id: fid_model, frame: mk(24'h900)});
        fid_model++;
        for (int k = 0; k < NCH; k++) begin
            if (k == NCH - 1) out_ready = 1'b1;
            beat(k, 24'h900 + 24'(k), 1'b0);
        end
        checks++;
        if (out_valid !== 1'b1 || out_frame_id !== 8'd1 || out_frame !== mk(24'h900)) begin
            errors++;
            $display("FAIL b2b_reload: valid=%b id=%0d, required 1/1", out_valid, out_frame_id);
        end
        idle(2);
        check_drained("b2b");
    endtask

    task automatic test_async_reset();
        do_reset();
        send_frame(24'hA00, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) beat(k, 24'hB00 + 24'(k), 1'b0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        fid_model = '0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_frame !== '0 || out_frame_id !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b id=%0d, required 0/0", out_valid, out_frame_id);
        end
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(1);
        send_frame(24'hC00, 1'b1, 1'b0);
        checks++;
        if (out_frame_id !== 8'd0 || out_frame !== mk(24'hC00)) begin
            errors++;
            $display("FAIL async_reset_id: id=%0d, required 0", out_frame_id);
        end
        idle(2);
        check_drained("async_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_seq();
        test_watchdog();
        test_clear();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
